// File: rtl/zz_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : zz_pkg
//  Description : Shared constants for the zigzag reorder buffer: block size,
//                data width, address widths and the raster-to-zigzag lookup
//                table (entry k holds the raster index of zigzag position k).
//  Revision    : 1.0 - initial release
// ============================================================================
package zz_pkg;

  localparam int BLK_SIZE = 64;
  localparam int DATA_W   = 8;
  localparam int IDX_W    = 6;
  localparam int ADDR_W   = IDX_W + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = 6'd63;

  // Zigzag scan of an 8x8 block, row-major raster indices.
  localparam logic [IDX_W-1:0] ZZ_LUT [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage : zz_pkg
`default_nettype wire

// File: rtl/dp_ram_8bx128.sv
`default_nettype none
// ============================================================================
//  Module      : dp_ram_8bx128
//  Description : 128 x 8 simple dual-port RAM, one write port and one
//                registered read port. Contents are never reset.
//  Ports       : clk          - clock (posedge)
//                we/waddr/din - write enable, address, data
//                re/raddr     - read enable, address
//                dout         - registered read data, updated only when re=1
//  Revision    : 1.0 - initial release
// ============================================================================
module dp_ram_8bx128
  import zz_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] din,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [2*BLK_SIZE];
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= din;
    end
  end

  // Holding dout when re=0 is what keeps the output word stable under stall.
  always_ff @(posedge clk) begin
    if (re) begin
      dout_q <= mem_q[raddr];
    end
  end

  assign dout = dout_q;

endmodule : dp_ram_8bx128
`default_nettype wire

// File: rtl/zigzag_buf.sv
`default_nettype none
// ============================================================================
//  Module      : zigzag_buf
//  Description : Ping-pong 8x8 block buffer. Coefficients are written in
//                raster order into one bank while the other bank is read
//                out in zigzag order.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                in_valid/in_ready     - write-side handshake
//                in_data               - raster-order coefficient
//                out_valid/out_ready   - read-side handshake
//                out_data              - zigzag-order coefficient
//                out_last              - marks zigzag index 63
//  Revision    : 1.0 - initial release
// ============================================================================
module zigzag_buf
  import zz_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  logic [IDX_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [IDX_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       full_q, full_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;

  logic             wr_fire;
  logic             rd_issue;
  logic             full_set;
  logic             full_clr;

  // in_ready depends on registers only, so it never loops back on in_valid.
  assign in_ready = !full_q[wr_bank_q];
  assign wr_fire  = in_valid && in_ready;

  // Issue a read whenever the output register is empty or being drained.
  assign rd_issue = full_q[rd_bank_q] && (!out_valid_q || out_ready);

  assign full_set = wr_fire  && (wr_cnt_q == LAST_IDX);
  assign full_clr = rd_issue && (rd_cnt_q == LAST_IDX);

  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    full_d      = full_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end
    if (full_set) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end

    if (rd_issue) begin
      rd_cnt_d    = rd_cnt_q + 1'b1;
      out_valid_d = 1'b1;
      out_last_d  = (rd_cnt_q == LAST_IDX);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // A bank being written is never full and a bank being read always is,
    // so this clear can never collide with the set above.
    if (full_clr) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  dp_ram_8bx128 u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr ({wr_bank_q, wr_cnt_q}),
    .din   (in_data),
    .re    (rd_issue),
    .raddr ({rd_bank_q, ZZ_LUT[rd_cnt_q]}),
    .dout  (out_data)
  );

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

`ifndef SYNTHESIS
  a_full_no_collide : assert property (@(posedge clk) disable iff (!rst_n)
    !(full_set && full_clr && (wr_bank_q == rd_bank_q)));
`endif

endmodule : zigzag_buf
`default_nettype wire

// File: tb/tb_zigzag_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_zigzag_buf
//  Description : Scoreboard bench for zigzag_buf. The driver records every
//                accepted coefficient; each completed block pushes its 64
//                zigzag-ordered words into a queue that an independent
//                monitor pops on every output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_zigzag_buf;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       out_ready = 1'b1;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t       sbq[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         zz_ref[64];
  logic [7:0] blk_buf[64];
  int         blk_fill = 0;
  int         blk_seq = 0;
  int         acc_total = 0;
  int         pop_cnt = 0;
  bit         rdy_rand = 1'b0;

  always #5 clk = ~clk;

  zigzag_buf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  // Reference zigzag order built by walking the anti-diagonals of an 8x8 grid.
  function automatic void build_zz();
    int k;
    int lo;
    int hi;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_ref[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_ref[k] = r * 8 + (s - r); k++; end
      end
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive n accepted words; mode 0 = sequential block data, 1 = random
  // valid and data, 2 = 100 + raster index.
  task automatic drive_words(input int n, input int mode, output int attempts);
    int   sent;
    exp_t e;
    sent = 0;
    attempts = 0;
    while (sent < n) begin
      @(posedge clk); #1;
      case (mode)
        0:       begin in_valid = 1'b1; in_data = 8'((blk_seq * 64 + blk_fill) & 255); end
        1:       begin in_valid = 1'($urandom_range(0, 1)); in_data = 8'($urandom); end
        default: begin in_valid = 1'b1; in_data = 8'(100 + blk_fill); end
      endcase
      @(negedge clk);
      if (in_valid) attempts++;
      if (in_valid && in_ready) begin
        blk_buf[blk_fill] = in_data;
        blk_fill++;
        acc_total++;
        sent++;
        if (blk_fill == 64) begin
          for (int k = 0; k < 64; k++) begin
            e.d = blk_buf[zz_ref[k]];
            e.l = (k == 63);
            sbq.push_back(e);
          end
          blk_fill = 0;
          blk_seq++;
        end
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int w;
    w = 0;
    while ((sbq.size() != 0 || out_valid) && w < max_cyc) begin
      @(negedge clk);
      w++;
    end
    if (w >= max_cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", sbq.size());
    end
  endtask

  // Random out_ready generator, active only while rdy_rand is set.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks that a stalled
  // word holds steady until it is taken.
  initial begin
    bit         prev_stall;
    logic [7:0] prev_d;
    logic       prev_l;
    exp_t       e;
    prev_stall = 1'b0;
    prev_d = 8'd0;
    prev_l = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          vectors++;
          if (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l) begin
            miscompares++;
            $display("FAIL stall_hold: got v=%0b d=%0d l=%0b expected v=1 d=%0d l=%0b",
                     out_valid, out_data, out_last, prev_d, prev_l);
          end
        end
        if (out_valid && out_ready) begin
          pop_cnt++;
          vectors++;
          if (sbq.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_out: got d=%0d expected no output", out_data);
          end else begin
            e = sbq.pop_front();
            if (out_data !== e.d || out_last !== e.l) begin
              miscompares++;
              $display("FAIL sb_word: got d=%0d l=%0b expected d=%0d l=%0b",
                       out_data, out_last, e.d, e.l);
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_d = out_data;
        prev_l = out_last;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int att;
    int g;
    int w;
    int acc0;
    int pop0;
    build_zz();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single block, data = raster index; first output two cycles after last write
    blk_seq = 0;
    drive_words(64, 0, att);
    @(negedge clk);
    chk("lat_not_yet", int'(out_valid), 0);
    @(negedge clk);
    chk("lat_first_valid", int'(out_valid), 1);
    chk("lat_first_data", int'(out_data), 0);
    wait_drain(200);

    // Four back-to-back blocks, both sides always ready
    blk_seq = 0;
    fork
      drive_words(256, 0, att);
      begin
        g = 0;
        w = 0;
        while (!out_valid && w < 500) begin @(negedge clk); w++; end
        for (int k = 0; k < 256; k++) begin
          if (!out_valid) g++;
          @(negedge clk);
        end
        chk("b2b_out_gaps", g, 0);
      end
    join
    chk("b2b_in_cycles", att, 256);
    wait_drain(200);

    // Output stalled for 200 cycles while three blocks are offered
    blk_seq = 0;
    out_ready = 1'b0;
    acc0 = acc_total;
    fork
      drive_words(192, 0, att);
      begin
        repeat (200) @(negedge clk);
        chk("stall_accepted", acc_total - acc0, 128);
        chk("stall_in_ready", int'(in_ready), 0);
        chk("stall_out_valid", int'(out_valid), 1);
        chk("stall_out_data", int'(out_data), 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_drain(400);

    // Random handshakes on both sides, 20 blocks of random data
    rdy_rand = 1'b1;
    drive_words(1280, 1, att);
    wait_drain(4000);
    rdy_rand = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain(100);

    // Reset after 40 words of a block
    drive_words(40, 2, att);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_last", int'(out_last), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    blk_fill = 0;
    pop0 = pop_cnt;
    drive_words(64, 2, att);
    @(negedge clk);
    @(negedge clk);
    chk("postrst_first", int'(out_data), 100);
    wait_drain(200);
    chk("postrst_count", pop_cnt - pop0, 64);

    // Stall on out_last while the second bank is full
    blk_seq = 0;
    out_ready = 1'b0;
    drive_words(128, 0, att);
    out_ready = 1'b1;
    w = 0;
    while (w < 200) begin
      @(posedge clk); #1;
      w++;
      if (out_valid && out_last) begin
        out_ready = 1'b0;
        break;
      end
    end
    chk("last_found", int'(w < 200), 1);
    repeat (5) begin
      @(negedge clk);
      chk("last_hold_data", int'(out_data), 63);
      chk("last_hold_flag", int'(out_last), 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("after_last_valid", int'(out_valid), 1);
    chk("after_last_data", int'(out_data), 64);
    chk("after_last_flag", int'(out_last), 0);
    wait_drain(200);

    chk("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_zigzag_buf
`default_nettype wire
